ram8x8_bist: RTL
================

# ram8x8_bist

Built-in self-test engine for the RAM8x8 macro and the master side of its clk/D/Q/addr/we port. On `start` it runs a March C- sequence of writes and read-compares over every word, then reports pass/fail with first-failure diagnostics. It sits beside each RAM8x8 instance and muxes onto the RAM port during test; system logic owns the port when `busy` is low.

## Interface
- `AW`, 3, address width; words = 2**AW
- `DW`, 8, data width
- `clk`  in  1  clock; RAM samples D/addr/we on the same rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  begin test; sampled only when idle
- `busy`  out  1  test running; engine owns the RAM port
- `done`  out  1  one-cycle pulse at test end
- `pass`  out  1  result; valid from `done`, held until next accepted `start`
- `fail_addr`  out  AW  address of first miscompare
- `fail_bits`  out  DW  `ram_Q ^ expected` at first miscompare
- `ram_D`  out  DW  write data to RAM
- `ram_Q`  in  DW  read data from RAM
- `ram_addr`  out  AW  RAM address
- `ram_we`  out  1  RAM write enable

## Operation
- RAM contract (decided): a write commits at the rising edge with `we=1`. Read data for the address sampled at edge n is valid on `ram_Q` during cycle n+1.
- March elements, with background B and its complement ~B:
  - M0 ⇑ w(B)
  - M1 ⇑ r(B), w(~B)
  - M2 ⇑ r(~B), w(B)
  - M3 ⇓ r(B), w(~B)
  - M4 ⇓ r(~B), w(B)
  - M5 ⇑ r(B)
- Default B = 8'h00. ⇑ is address 0→7; ⇓ is address 7→0.
- FSM states: IDLE, WR (M0), RD (present addr, we=0), CMPW (compare, then write at same addr), CMP (M5 compare only), FIN.
- Transitions:
  - IDLE → WR on `start`.
  - WR loops over 8 addresses, then → RD.
  - RD → CMPW (M1–M4) or → CMP (M5).
  - CMPW/CMP → RD with the next address. At the terminal address, advance to the next element.
  - After the last M5 compare → FIN → IDLE.
- Compare: a mismatch while `pass_r` is still 1 captures `fail_addr`/`fail_bits` and clears `pass_r`. Later mismatches are ignored. The test always runs to completion; there is no early abort.
- `ram_we` is high only in WR and CMPW.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `fail_addr`=0, `fail_bits`=0, `ram_D`=0, `ram_addr`=0, `ram_we`=0.
- Cycle budget: `start` sampled at edge 0. First RAM op is in cycle 1.
- RAM op cycles per background:
  - M0: 8
  - M1–M4: 16 each (2 per address)
  - M5: 16
  - Total: 88
- Single background: `done` pulses and `busy` falls in cycle 89. `pass` is updated in the same cycle.
- `start` while busy is ignored. `start` and `rst` in the same cycle: `rst` wins.
- `rst` mid-test: all outputs reach reset values at the next edge, `ram_we` included. No further RAM writes occur, and no `done` pulse is issued.

## Configuration
- `RAM8X8_BIST_CHECKERBOARD_EN` defined: after the B=8'h00 pass, the full sequence repeats with B=8'h55. Total 176 RAM op cycles; `done` is in cycle 177. `fail_*` records the first failure across both passes.
- Undefined: single 8'h00 pass only. No checkerboard logic is synthesized.

## Structure
- Package `ram_bist_pkg` holds:
  - the FSM state enum;
  - the march element index type and per-element direction/read-value/write-value table;
  - background constants `BG0`=8'h00 and `BG1`=8'h55;
  - `OPS_PER_BG`=88.
- Sub-module `ram_bist_addr_gen`: an AW-bit up/down counter with `load`, `dir`, and a `last` flag. It is the natural split; keep the FSM in the top.

## Test plan
- Fault-free behavioral RAM, `start` pulse → `busy` 1 from cycle 1, `done` pulse in cycle 89, `pass`=1, `fail_addr`=0, `fail_bits`=0.
- Stuck-at-0 on bit 3 at address 5 → `pass`=0, `fail_addr`=5, `fail_bits`=8'h08; `done` still in cycle 89.
- Coupling fault (write to address 2 inverts bit 0 of address 6) → `pass`=0, `fail_addr`=6, `fail_bits`=8'h01.
- `rst` asserted in cycle 30 → `ram_we`=0 and `busy`=0 from next cycle, no `done`. A new `start` then completes with `pass`=1 at +89.
- `start` re-pulsed in cycles 10 and 50 → ignored; exactly one `done`, in cycle 89.
- Macro defined, bits 0/1 bridged (AND) at address 4 → `done` in cycle 177, `pass`=0, `fail_addr`=4, `fail_bits`=8'h01. Without the macro, the same fault yields `pass`=1.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared types and constants for the RAM8x8 March C- BIST engine.
// Contents: FSM state enum, march element index type with its per-element
// direction / read-polarity / write-polarity table, background constants
// and the RAM op count per background.
// Build option: RAM8X8_BIST_CHECKERBOARD_EN (used by ram8x8_bist) adds a
// second pass with background BG1.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_CMPW = 3'd3,
        ST_CMP  = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } elem_t;

    localparam logic [7:0] BG0        = 8'h00;
    localparam logic [7:0] BG1        = 8'h55;
    localparam int         OPS_PER_BG = 88;

    // Element walks addresses high-to-low (M3, M4).
    function automatic logic elem_down(input elem_t e);
        case (e)
            M3, M4:  elem_down = 1'b1;
            default: elem_down = 1'b0;
        endcase
    endfunction

    // Element expects the complemented background on its read (M2, M4).
    function automatic logic elem_rd_inv(input elem_t e);
        case (e)
            M2, M4:  elem_rd_inv = 1'b1;
            default: elem_rd_inv = 1'b0;
        endcase
    endfunction

    // Element writes the complemented background (M1, M3).
    function automatic logic elem_wr_inv(input elem_t e);
        case (e)
            M1, M3:  elem_wr_inv = 1'b1;
            default: elem_wr_inv = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen: AW-bit up/down address counter for the march engine.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - start a new element: addr goes to 0 (dir=0) or max (dir=1)
//   step      - advance one address in the direction captured at load
//   dir       - direction for the element being loaded (1 = descending)
//   addr      - current address (registered)
//   last      - addr is the terminal address of the current direction
module ram_bist_addr_gen #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic          dir,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic dir_r;

    // Address counter; direction is latched at load so 'last' and 'step'
    // always refer to the element currently running.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr  <= {AW{1'b0}};
            dir_r <= 1'b0;
        end else if (load) begin
            dir_r <= dir;
            addr  <= dir ? {AW{1'b1}} : {AW{1'b0}};
        end else if (step) begin
            addr  <= dir_r ? (addr - {{(AW-1){1'b0}}, 1'b1})
                           : (addr + {{(AW-1){1'b0}}, 1'b1});
        end else begin
            addr  <= addr;
        end
    end

    assign last = dir_r ? (addr == {AW{1'b0}}) : (addr == {AW{1'b1}});

endmodule

// File: rtl/ram8x8_bist.sv
// ram8x8_bist: March C- built-in self-test engine driving a RAM8x8 port.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - begin a test (only accepted when idle)
//   busy                - engine owns the RAM port
//   done                - one-cycle pulse at end of test
//   pass                - test result, valid from done
//   fail_addr/fail_bits - address and XOR syndrome of the first miscompare
//   ram_D/ram_Q/ram_addr/ram_we - RAM port (read data valid one cycle after
//                                 the address is presented)
// Build option: RAM8X8_BIST_CHECKERBOARD_EN repeats the march with
// background 8'h55 after the 8'h00 pass.
module ram8x8_bist
    import ram_bist_pkg::*;
#(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_bits,
    output logic [DW-1:0] ram_D,
    input  logic [DW-1:0] ram_Q,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we
);

    state_t        state_r;
    elem_t         elem_r;
    logic          pass_r;
    logic [DW-1:0] bg_s;
    logic          bg_more_s;
    logic [DW-1:0] exp_rd_s;
    logic [DW-1:0] wr_val_s;
    logic          mism_s;
    logic          load_s;
    logic          step_s;
    logic          load_dir_s;
    logic [AW-1:0] addr_s;
    logic          last_s;

`ifdef RAM8X8_BIST_CHECKERBOARD_EN
    logic [DW-1:0] bg_r;
    assign bg_s      = bg_r;
    assign bg_more_s = (bg_r == DW'(BG0));
`else
    assign bg_s      = DW'(BG0);
    assign bg_more_s = 1'b0;
`endif

    // Expected read value, write value and compare result for the current element.
    always_comb begin
        exp_rd_s = bg_s ^ (elem_rd_inv(elem_r) ? {DW{1'b1}} : {DW{1'b0}});
        wr_val_s = bg_s ^ (elem_wr_inv(elem_r) ? {DW{1'b1}} : {DW{1'b0}});
        mism_s   = (ram_Q != exp_rd_s);
    end

    // Address counter control: load at each element start, step between addresses.
    always_comb begin
        load_s     = 1'b0;
        step_s     = 1'b0;
        load_dir_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_WR: begin
                if (last_s) begin
                    load_s     = 1'b1;
                    load_dir_s = elem_down(M1);
                end else begin
                    step_s = 1'b1;
                end
            end
            ST_CMPW, ST_CMP: begin
                if (last_s) begin
                    if (elem_r == M5) begin
                        // Only reload when another background follows.
                        load_s = bg_more_s;
                    end else begin
                        load_s     = 1'b1;
                        load_dir_s = elem_down(elem_t'(elem_r + 3'd1));
                    end
                end else begin
                    step_s = 1'b1;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    ram_bist_addr_gen #(.AW(AW)) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .load (load_s),
        .step (step_s),
        .dir  (load_dir_s),
        .addr (addr_s),
        .last (last_s)
    );

    assign ram_addr = addr_s;

    // March sequencer with registered RAM controls and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            elem_r    <= M0;
            pass_r    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= {AW{1'b0}};
            fail_bits <= {DW{1'b0}};
            ram_D     <= {DW{1'b0}};
            ram_we    <= 1'b0;
`ifdef RAM8X8_BIST_CHECKERBOARD_EN
            bg_r      <= DW'(BG0);
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r   <= ST_WR;
                        elem_r    <= M0;
                        pass_r    <= 1'b1;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        fail_addr <= {AW{1'b0}};
                        fail_bits <= {DW{1'b0}};
                        ram_D     <= DW'(BG0);
                        ram_we    <= 1'b1;
`ifdef RAM8X8_BIST_CHECKERBOARD_EN
                        bg_r      <= DW'(BG0);
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    if (last_s) begin
                        state_r <= ST_RD;
                        elem_r  <= M1;
                        ram_we  <= 1'b0;
                    end else begin
                        ram_we  <= 1'b1;
                        ram_D   <= bg_s;
                    end
                end
                ST_RD: begin
                    // Read data arrives next cycle; write-back (if any) shares that cycle.
                    if (elem_r == M5) begin
                        state_r <= ST_CMP;
                        ram_we  <= 1'b0;
                    end else begin
                        state_r <= ST_CMPW;
                        ram_we  <= 1'b1;
                    end
                    ram_D <= wr_val_s;
                end
                ST_CMPW, ST_CMP: begin
                    // First miscompare wins; later ones are ignored.
                    if (mism_s && pass_r) begin
                        pass_r    <= 1'b0;
                        fail_addr <= addr_s;
                        fail_bits <= ram_Q ^ exp_rd_s;
                    end else begin
                        pass_r    <= pass_r;
                    end
                    ram_we  <= 1'b0;
                    state_r <= ST_RD;
                    if (last_s) begin
                        if (elem_r == M5) begin
                            if (bg_more_s) begin
                                state_r <= ST_WR;
                                elem_r  <= M0;
                                ram_we  <= 1'b1;
                                ram_D   <= DW'(BG1);
`ifdef RAM8X8_BIST_CHECKERBOARD_EN
                                bg_r    <= DW'(BG1);
`endif
                            end else begin
                                state_r <= ST_FIN;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                pass    <= pass_r & ~mism_s;
                            end
                        end else begin
                            elem_r <= elem_t'(elem_r + 3'd1);
                        end
                    end else begin
                        elem_r <= elem_r;
                    end
                end
                ST_FIN: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    ram_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
